icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning index width; frames = 2**IDX_W, tag width = 30-IDX_W.
REQ-002 SHALL have CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have imemREN  input  1  datapath instruction read request.
REQ-005 SHALL have imemaddr  input  32  datapath instruction byte address (word aligned).
REQ-006 SHALL have ihit  output  1  requested word valid on imemload this cycle.
REQ-007 SHALL have imemload  output  32  instruction word to datapath.
REQ-008 SHALL have flush  input  1  invalidate all frames.
REQ-009 SHALL have iREN  output  1  memory-side read request.
REQ-010 SHALL have iaddr  output  32  memory-side word address, bits[1:0]=00.
REQ-011 SHALL have iwait  input  1  memory busy; iload valid in a cycle with iREN=1, iwait=0.
REQ-012 SHALL have iload  input  32  memory-side read data.

Function
REQ-013 SHALL be direct-mapped, one word per frame: index=addr[IDX_W+1:2], tag=addr[31:IDX_W+2].
REQ-014 SHALL hold per frame a valid bit, tag, 32-bit data word.
REQ-015 SHALL use FSM states IDLE and FETCH.
REQ-016 SHALL in IDLE assert ihit combinationally when imemREN=1, valid[index]=1, tag match; imemload=data[index] same cycle (zero-cycle hit).
REQ-017 SHALL drive ihit=0 when imemREN=0, on miss, and in every FETCH cycle; imemload=data[index] otherwise don't-care but deterministic.
REQ-018 SHALL on IDLE miss (imemREN=1, no hit) latch {imemaddr[31:2],2'b00} into miss register and go to FETCH next edge.
REQ-019 SHALL in FETCH assert iREN=1, iaddr=miss register; iREN=0 and iaddr=0 in IDLE.
REQ-020 SHALL on FETCH cycle with iwait=0 write iload, latched tag, valid=1 to latched index and return to IDLE at that edge.
REQ-021 SHALL keep FETCH until iwait=0 even if imemREN drops or imemaddr changes; fill uses latched address only.
REQ-022 SHALL after a fill re-evaluate in IDLE: same address hits the cycle after fill; miss latency = 1 + memory wait cycles + 1.
REQ-023 SHALL on flush=1 clear all valid bits at the next edge, any state.
REQ-024 SHALL when flush=1 coincides with fill edge leave the frame invalid (flush wins) and still return to IDLE.
REQ-025 SHALL force ihit=0 in any cycle flush=1.
REQ-026 SHALL replace conflicting frame on fill (no write-back; read-only cache).

Reset
REQ-027 SHALL on nRST=0 immediately: state IDLE, all valid=0, tags/data/miss register=0, iREN=0, ihit=0.
REQ-028 SHALL on reset during FETCH abandon the fetch; no frame written.
REQ-029 SHALL resume normal operation first rising edge after nRST deasserts.

Configuration
REQ-030 SHALL with macro ICACHE_STATS_EN defined add outputs hit_count (output, 32) and miss_count (output, 32).
REQ-031 SHALL with ICACHE_STATS_EN increment hit_count each cycle ihit=1, miss_count each IDLE->FETCH transition; both wrap at 2**32, reset to 0, unaffected by flush.
REQ-032 SHALL without ICACHE_STATS_EN omit both ports and counters; all other behaviour identical.

Verification
REQ-033 SHALL cover cold miss: reset, imemREN=1, imemaddr=0x00000040, memory iwait=1 two cycles then iload=0x20010005 -> iREN=1 iaddr=0x40 three cycles, ihit=1 imemload=0x20010005 next cycle.
REQ-034 SHALL cover conflict: fill 0x00000004, then request 0x00000044 (same index 1, new tag) -> miss, fetch 0x44; re-request 0x04 -> miss again.
REQ-035 SHALL cover flush: fill 0x08, assert flush one cycle -> ihit=0 that cycle, next request 0x08 misses.
REQ-036 SHALL cover flush on fill edge: flush=1 with iwait=0 in FETCH for 0x0C -> IDLE, following 0x0C request misses.
REQ-037 SHALL cover address change mid-fetch: miss 0x10, change imemaddr to 0x14 during FETCH -> frame 4 filled with tag of 0x10, then 0x14 misses.
REQ-038 SHALL cover stats (ICACHE_STATS_EN): sequence miss 0x0, 3 hit cycles on 0x0, miss 0x4 -> hit_count=3, miss_count=2.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame read-only instruction cache with zero-cycle hits.
// Optional `ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache #(
   parameter int IDX_W = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        flush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int TAG_W  = 30 - IDX_W;
   localparam int FRAMES = 2 ** IDX_W;
   typedef enum logic {IDLE, FETCH} state_t;
   state_t r_state, w_next;
   logic [FRAMES-1:0] r_valid;
   logic [TAG_W-1:0]  r_tag  [FRAMES];
   logic [31:0]       r_data [FRAMES];
   logic [31:0]       r_miss;
   logic [IDX_W-1:0]  w_idx, w_midx;
   logic [TAG_W-1:0]  w_tag, w_mtag;
   logic              w_hit, w_miss, w_fill;
   assign w_idx    = imemaddr[IDX_W+1:2];
   assign w_tag    = imemaddr[31:IDX_W+2];
   assign w_midx   = r_miss[IDX_W+1:2];
   assign w_mtag   = r_miss[31:IDX_W+2];
   assign w_hit    = r_state == IDLE && imemREN && !flush && r_valid[w_idx] && r_tag[w_idx] == w_tag;
   assign w_miss   = r_state == IDLE && imemREN && !w_hit;
   assign w_fill   = r_state == FETCH && !iwait;
   assign ihit     = w_hit;
   assign imemload = r_data[w_idx];
   always_comb begin
      w_next = r_state;
      iREN   = 1'b0;
      iaddr  = '0;
      if (w_miss) w_next = FETCH;
      if (r_state == FETCH) begin
         iREN   = 1'b1;
         iaddr  = r_miss;
         w_next = iwait ? FETCH : IDLE;
      end
   end
   // Fill uses only the latched miss address; flush is applied last so it wins on a fill edge.
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_valid <= '0;
         r_miss  <= '0;
         for (int i = 0; i < FRAMES; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         if (w_miss) r_miss <= imemaddr & 32'hFFFF_FFFC;
         if (w_fill) begin
            r_data[w_midx]  <= iload;
            r_tag[w_midx]   <= w_mtag;
            r_valid[w_midx] <= 1'b1;
         end
         if (flush) r_valid <= '0;
      end
   end
`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (w_hit) hit_count <= hit_count + 32'd1;
         if (w_miss) miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule
